// File: rtl/reg_file_bram_mp.sv
// Multi-read-port register file built from one BRAM bank per read port, with a
// post-reset zero-fill sequencer. Optional write-to-read forwarding: define RF_WR_BYPASS_EN.
module reg_file_bram_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_RD_PORTS = 2,
  parameter int ZERO_REG_EN  = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic                               init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rd_ok_q, rd_ok_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    rd_ok_d   = (state_q == RUN);
    unique case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        mem_we = wr_en && !((ZERO_REG_EN != 0) && (wr_addr == '0));
      end
      default: state_d = INIT;
    endcase
    // A reset edge restarts the fill, so it must not also commit a write.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  assign init_done = (state_q == RUN);

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rd_raw_q;
    logic                  is_zero;

    assign raddr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // NOTE: no reset on the array or read register -- BRAM cannot be reset, so the
    // zero-fill clears it and rd_ok_q masks the read path until the fill ends.
    // Non-blocking read and write on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_raw_q  <= mem[raddr];
      rd_addr_q <= raddr;
    end

    assign is_zero = (ZERO_REG_EN != 0) && (rd_addr_q == '0);

`ifdef RF_WR_BYPASS_EN
    logic                  fwd_hit_d, fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    always_comb begin
      fwd_hit_d = mem_we && (state_q == RUN) && (wr_addr == raddr);
    end

    always_ff @(posedge clk) begin
      if (rst) fwd_hit_q <= 1'b0;
      else     fwd_hit_q <= fwd_hit_d;
      fwd_data_q <= wr_data;
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
      (!rd_ok_q || is_zero) ? '0 : (fwd_hit_q ? fwd_data_q : rd_raw_q);
`else
    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = (!rd_ok_q || is_zero) ? '0 : rd_raw_q;
`endif
  end

endmodule

// File: tb/tb_reg_file_bram_mp.sv
// Directed, table-driven bench for reg_file_bram_mp (default parameters).
module tb_reg_file_bram_mp;

`ifdef RF_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        init_done;

  int checks = 0;
  int failures = 0;

  reg_file_bram_mp dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = {r1, r0};
  endtask

  // One reset edge, then count edges until init_done; optionally pulse a write at edge 3.
  task automatic reset_and_fill(input bit pulse, output int n);
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    step();
    check("init_done_in_rst", {31'd0, init_done}, 32'd0);
    check("rd_data_in_rst", rd_data[31:0] | rd_data[63:32], 32'd0);
    rst = 1'b0;
    n = 0;
    do begin
      if (pulse && n == 2) drive(1'b1, 5'd5, 32'h12345678, 5'd7, 5'd7);
      else                 drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
      step();
      n++;
      if (n == 5) check("rd_data_in_init", rd_data[31:0] | rd_data[63:32], 32'd0);
    end while (!init_done && n < 100);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  vec_t vecs[12];
  int   n;

  initial begin
    vecs[0]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd0,  5'd0,  32'h0, 32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd9,  32'h11111111, 5'd3,  5'd4,  32'h0, 32'h0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'h11111111, 32'h11111111};
    vecs[6]  = '{1'b1, 5'd9,  32'h22222222, 5'd9,  5'd7,
                 BYP ? 32'h22222222 : 32'h11111111, 32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd9,  32'h22222222, 32'h22222222};
    vecs[8]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd1,  32'h0, 32'h0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[10] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31,
                 BYP ? 32'h00000001 : 32'h0, 32'hCAFEF00D};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0, 32'h00000001};

    // Power-up: hold reset a few cycles, then the fill must take exactly 32 edges.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    repeat (3) step();
    reset_and_fill(1'b0, n);
    check("init_edges_powerup", n, 32);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].ra0, vecs[i].ra1);
      step();
      check($sformatf("vec%0d_p0", i), rd_data[31:0], vecs[i].exp0);
      check($sformatf("vec%0d_p1", i), rd_data[63:32], vecs[i].exp1);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Fill every entry with a marker, confirm it landed, then re-zero by reset.
    for (int a = 0; a < 32; a++) begin
      drive(1'b1, 5'(a), 32'hDEADBEEF, 5'd0, 5'd0);
      step();
    end
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
    step();
    check("marker_p0", rd_data[31:0], 32'hDEADBEEF);
    check("marker_p1", rd_data[63:32], 32'hDEADBEEF);

    reset_and_fill(1'b1, n);
    check("init_edges_refill", n, 32);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(a));
      step();
      check($sformatf("zero_p0_a%0d", a), rd_data[31:0], 32'd0);
      check($sformatf("zero_p1_a%0d", a), rd_data[63:32], 32'd0);
    end

    // Reset landing mid-fill (counter at 10) restarts the whole sequence.
    drive(1'b1, 5'd12, 32'hBADC0DE5, 5'd0, 5'd0);
    step();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    rst = 1'b0;
    repeat (10) step();
    check("init_done_mid_fill", {31'd0, init_done}, 32'd0);
    reset_and_fill(1'b0, n);
    check("init_edges_restart", n, 32);
    drive(1'b0, 5'd0, 32'd0, 5'd12, 5'd31);
    step();
    check("restart_zero_p0", rd_data[31:0], 32'd0);
    check("restart_zero_p1", rd_data[63:32], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_bram_mp.md
Name: reg_file_bram_mp

Overview:
Parametrised successor to the core's SRAM-style register file, inferred as block RAM on FPGA. Provides NUM_RD_PORTS independent synchronous read ports and one write port by replicating one storage bank per read port. Adds a post-reset zero-fill sequencer, since BRAM contents have no reset. Adds optional same-cycle write-to-read forwarding. Sits in the RV32I core decode stage, feeding operand registers.

Parameters:
DATA_WIDTH, 32, width of each register entry
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH entries
NUM_RD_PORTS, 2, number of independent read ports (banks), 1..4
ZERO_REG_EN, 1, when 1 entry 0 is hardwired to zero (RISC-V x0)

Ports:
clk  in  1  core clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write strobe, active-high
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
rd_addr  in  NUM_RD_PORTS*ADDR_WIDTH  packed read addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD_PORTS*DATA_WIDTH  packed read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
init_done  out  1  high once zero-fill is complete and the file accepts writes

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on rising clk). While rst=1: FSM -> INIT, fill counter = 0, init_done = 0, all rd_data = 0. Storage contents are not reset directly.
- FSM states are INIT and RUN.
- INIT: each edge with rst=0 writes zero to entry [counter] in every bank, then increments counter.
- INIT -> RUN: on the edge that writes entry DEPTH-1. init_done is registered and reads 1 after that edge, i.e. DEPTH edges after rst deasserts (32 for defaults).
- In INIT: external wr_en is ignored (dropped, not queued) and every rd_data reads 0.
- RUN: on a rising edge with wr_en=1, wr_data is written to wr_addr in all banks simultaneously. When ZERO_REG_EN=1 and wr_addr=0, the write is suppressed.
- Read latency is 1 cycle. rd_addr[p] is sampled on edge N. rd_data[p] is valid after edge N and holds until edge N+1.
- Zero register: when ZERO_REG_EN=1 and the sampled rd_addr[p]=0, rd_data[p]=0 regardless of bank content (compare the registered address).
- Same-address read and write on one edge, without forwarding: read-first. rd_data returns the old value; the new value is visible from the next read.
- Multiple ports may read the same address in one cycle; all return identical data.
- rst asserted mid-INIT or in RUN: the FSM returns to INIT, counter restarts at 0, and all entries are re-zeroed. Partially filled state is never exposed.
- Counter is ADDR_WIDTH+1 bits wide, so the terminal compare does not wrap.

Optional Feature:
Macro RF_WR_BYPASS_EN.
- Defined: adds a per-port forward register. On an edge where RUN, wr_en=1, and wr_addr equals rd_addr[p] (and is not 0 when ZERO_REG_EN=1), the port captures wr_data. rd_data[p] then returns wr_data in the following cycle (write-first). The zero-register rule still takes priority.
- Not defined: no forwarding logic; read-first behaviour as above.

Test Plan:
1. Zero-fill: write 0xDEADBEEF to all entries, then assert rst 1 cycle and wait for init_done. -> init_done rises exactly 32 edges after rst low; reading all 32 entries on both ports returns 0x00000000.
2. Write during INIT: pulse wr_en with addr 5, data 0x12345678 at edge 3 after reset. -> After init_done, reading addr 5 returns 0x00000000.
3. Basic write/read in RUN: write addr 7 = 0xA5A5A5A5, then read rd_addr = {7,7} next cycle. -> Both ports return 0xA5A5A5A5 one cycle after the address is sampled.
4. x0: write addr 0 = 0xFFFFFFFF, then read port0 = 0, port1 = 0. -> Both return 0x00000000.
5. Same-cycle collision: addr 9 holds 0x11111111; in one cycle write addr 9 = 0x22222222 while port0 reads 9. -> Returns 0x11111111 without RF_WR_BYPASS_EN and 0x22222222 with it; the next read returns 0x22222222 in both builds.
6. Reset mid-INIT: assert rst at counter = 10. -> init_done stays 0, the fill restarts at entry 0, and init_done rises 32 edges after the second rst deassertion.
